// File: rtl/leaf_port_arbiter_if.sv
// Leaf-port side of the arbiter: one output word with valid/accept.
// master drives the word, slave (the leaf interface) returns the accept.
interface leaf_port_arbiter_if #(
  parameter int PAYLOAD_BITS = 32
);
  logic [PAYLOAD_BITS-1:0] dout_leaf_user2interface;
  logic                    vld_user2interface;
  logic                    ack_interface2user;

  modport master (
    output dout_leaf_user2interface,
    output vld_user2interface,
    input  ack_interface2user
  );

  modport slave (
    input  dout_leaf_user2interface,
    input  vld_user2interface,
    output ack_interface2user
  );
endinterface

// File: rtl/leaf_port_arbiter.sv
// Round-robin burst arbiter feeding NUM_REQ requesters into one leaf port.
// Optional per-requester transfer counters when ARB_STATS_EN is defined.
module leaf_port_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = 32,
  parameter int BURST_LEN    = 8
) (
  input  logic                            clk_user,
  input  logic                            reset,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_din,
  input  logic [NUM_REQ-1:0]              req_vld,
  output logic [NUM_REQ-1:0]              req_ack,
  leaf_port_arbiter_if.master             leaf,
  output logic [2:0]                      grant_id,
  output logic [NUM_REQ*16-1:0]           stats_xfer_count
);

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_GRANT
  } state_t;

  localparam logic [7:0] LP_BLAST = 8'(BURST_LEN - 1);
  localparam logic [2:0] LP_LAST0 = 3'(NUM_REQ - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [2:0]              r_grant;
  logic [2:0]              w_grant_nxt;
  logic [2:0]              r_last;
  logic [2:0]              w_last_nxt;
  logic [7:0]              r_burst;
  logic [7:0]              w_burst_nxt;
  logic [PAYLOAD_BITS-1:0] r_dout;
  logic                    r_vld;

  logic                    w_any;
  logic                    w_hi_found;
  logic [2:0]              w_hi;
  logic [2:0]              w_lo;
  logic [2:0]              w_pick;
  logic                    w_sel_vld;
  logic [PAYLOAD_BITS-1:0] w_sel_din;
  logic                    w_ready;
  logic                    w_accept;

  assign w_any   = |req_vld;
  assign w_ready = ~r_vld | leaf.ack_interface2user;

  // Lowest valid index above last grant wins; otherwise wrap to lowest overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi       = '0;
    w_lo       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_vld[i]) begin
        if (3'(i) > r_last) begin
          w_hi_found = 1'b1;
          w_hi       = 3'(i);
        end else begin
          w_lo = 3'(i);
        end
      end
    end
    w_pick = w_hi_found ? w_hi : w_lo;
  end

  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant == 3'(i)) begin
        w_sel_vld = req_vld[i];
        w_sel_din = req_din[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_burst_nxt = r_burst;
    w_accept    = 1'b0;
    req_ack     = '0;
    unique case (r_state)
      ST_IDLE: begin
        w_burst_nxt = '0;
        if (w_any) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = w_pick;
        end
      end
      ST_GRANT: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (r_grant == 3'(i)) begin
            req_ack[i] = w_ready;
          end
        end
        w_accept = w_sel_vld & w_ready;
        if (!w_sel_vld || (w_accept && r_burst == LP_BLAST)) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_grant;
        end else if (w_accept) begin
          w_burst_nxt = r_burst + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_user) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= LP_LAST0;
      r_burst <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_burst <= w_burst_nxt;
    end
  end

  // Load wins over drain, giving back-to-back words with no bubble.
  always_ff @(posedge clk_user) begin
    if (reset) begin
      r_vld  <= 1'b0;
      r_dout <= '0;
    end else if (w_accept) begin
      r_vld  <= 1'b1;
      r_dout <= w_sel_din;
    end else if (leaf.ack_interface2user) begin
      r_vld  <= 1'b0;
    end
  end

  assign leaf.dout_leaf_user2interface = r_dout;
  assign leaf.vld_user2interface       = r_vld;
  assign grant_id = (r_state == ST_GRANT) ? r_grant : 3'd0;

`ifdef ARB_STATS_EN
  logic [15:0] r_stats [NUM_REQ];

  always_ff @(posedge clk_user) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reset) begin
        r_stats[i] <= '0;
      end else if (w_accept && r_grant == 3'(i)
                   && r_stats[i] != 16'hFFFF) begin
        r_stats[i] <= r_stats[i] + 16'd1;
      end
    end
  end

  always_comb begin
    stats_xfer_count = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stats_xfer_count[i*16 +: 16] = r_stats[i];
    end
  end
`else
  assign stats_xfer_count = '0;
`endif

endmodule

// File: doc/leaf_port_arbiter.md
LEAF_PORT_ARBITER -- requirements
Module: leaf_port_arbiter

Interface
REQ-001: Parameter NUM_REQ, default 4, number of user requesters sharing one leaf input port (2..8).
REQ-002: Parameter PAYLOAD_BITS, default 32, data word width.
REQ-003: Parameter BURST_LEN, default 8, max words per grant before re-arbitration (1..255).
REQ-004: clk_user  input  1  single clock; all logic on its rising edge.
REQ-005: reset  input  1  synchronous, active-high reset.
REQ-006: req_din  input  NUM_REQ*PAYLOAD_BITS  requester data, requester i at bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
REQ-007: req_vld  input  NUM_REQ  per-requester word valid.
REQ-008: req_ack  output  NUM_REQ  per-requester accept; transfer when req_vld[i] and req_ack[i] are both high in one cycle.
REQ-009: dout_leaf_user2interface  output  PAYLOAD_BITS  word to leaf interface input port.
REQ-010: vld_user2interface  output  1  dout valid.
REQ-011: ack_interface2user  input  1  leaf interface accept; transfer when vld and ack both high.
REQ-012: grant_id  output  3  index of current grant holder; 0 when idle.
REQ-013: stats_xfer_count  output  NUM_REQ*16  per-requester transfer counters (see Configuration).

Function
REQ-014: States IDLE and GRANT; one output register (data + valid) between requesters and leaf port.
REQ-015: IDLE: req_ack all low; if any req_vld high, next cycle enter GRANT with grant = first requester with req_vld high searching from (last_grant+1) mod NUM_REQ upward with wrap; burst count cleared.
REQ-016: GRANT: req_ack[grant] = (~vld_user2interface | ack_interface2user); all other req_ack low.
REQ-017: Accepted requester word appears on dout with vld high the following cycle (latency 1); output register holds unchanged while vld high and ack low.
REQ-018: Simultaneous drain and load in one cycle sustain one word per cycle with no bubble.
REQ-019: Output register clears vld on drain with no load in same cycle.
REQ-020: Burst count increments on each accepted word; accepting word number BURST_LEN forces GRANT -> IDLE next cycle.
REQ-021: In GRANT, req_vld[grant] low forces GRANT -> IDLE next cycle, regardless of ack.
REQ-022: On every GRANT -> IDLE transition last_grant <= grant, guaranteeing round-robin fairness; each arbitration costs one idle cycle.
REQ-023: Requester data is never dropped or duplicated; word order per requester preserved.
REQ-024: Output register drains normally while in IDLE.

Reset
REQ-025: On reset: state IDLE, vld_user2interface 0, dout 0, req_ack 0, grant_id 0, burst count 0, last_grant NUM_REQ-1 (first grant searches from requester 0), stats counters 0.
REQ-026: Reset mid-transfer discards any word in the output register; no partial state survives.

Configuration
REQ-027: Macro ARB_STATS_EN: when defined, one 16-bit counter per requester increments on each accepted word of that requester, saturating at 0xFFFF, cleared by reset.
REQ-028: Without ARB_STATS_EN, stats_xfer_count is tied to all zeros and no counter logic is built; all other behaviour identical.

Verification
REQ-029: Only req 2 valid with words 0xA0..0xA3, ack held high -> grant_id=2, words out in order 1 cycle after accept, vld continuous, then IDLE.
REQ-030: All 4 requesters continuously valid, BURST_LEN=8, ack high -> grants 0,1,2,3,0 each for exactly 8 words, one idle cycle between bursts.
REQ-031: Req 1 streaming, ack low for 5 cycles mid-burst -> dout/vld stable, req_ack[1] low those cycles, no word lost or duplicated.
REQ-032: Req 3 drops vld after 3 words while req 0 valid -> IDLE next cycle, then grant 0 (wrap from last_grant 3).
REQ-033: Reset asserted with vld high and word 0x55 pending -> next cycle vld 0, dout 0, grant_id 0, state IDLE.
REQ-034: With ARB_STATS_EN, 10 words from req 0 and 3 from req 1 -> counters read 10 and 3; without macro all read 0.
